puf_resp_ctrl: RTL and testbench

PUF_RESP_CTRL -- requirements
Module: puf_resp_ctrl

---
 rtl/puf_resp_ctrl.sv | 133 +++++++++++++
 tb/tb_puf_resp_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/puf_resp_ctrl.sv
// rtl/puf_resp_ctrl.sv - ring-oscillator PUF response controller, 8 challenges per response byte
// Each bit: clear counters, run both oscillator banks for WINDOW cycles, settle, then compare.
module puf_resp_ctrl #(
    parameter int WINDOW = 1024,
    parameter int SETTLE = 4,
    parameter int MARGIN = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  base_chal,
    input  logic [15:0] count_a,
    input  logic [15:0] count_b,
    output logic        ro_en,
    output logic        ro_clr,
    output logic [3:0]  ro_sel,
    output logic        busy,
    output logic [7:0]  resp,
    output logic [7:0]  resp_mask,
    output logic        resp_valid,
    input  logic        resp_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_SETTLE,
        S_CMP,
        S_DONE
    } state_t;

    state_t      state, state_next;
    logic [15:0] cnt;
    logic [2:0]  idx;
    logic [3:0]  sel;
    logic [16:0] diff;
    logic        cmp_bit;
    logic        cmp_unstable;
    logic        last_run;
    logic        last_settle;

    assign last_run    = (cnt == 16'(WINDOW - 1));
    assign last_settle = (cnt == 16'(SETTLE - 1));

    // 17-bit absolute difference so the full 16-bit range never overflows
    assign diff = (count_a >= count_b) ? ({1'b0, count_a} - {1'b0, count_b})
                                       : ({1'b0, count_b} - {1'b0, count_a});
    assign cmp_bit      = (count_a > count_b);
    assign cmp_unstable = (diff < 17'(MARGIN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ro_en      = 1'b0;
        ro_clr     = 1'b0;
        busy       = 1'b1;
        resp_valid = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_next = S_CLEAR;
            end
            S_CLEAR: begin
                ro_clr     = 1'b1;
                state_next = S_RUN;
            end
            S_RUN: begin
                ro_en = 1'b1;
                if (last_run) state_next = S_SETTLE;
            end
            S_SETTLE: begin
                if (last_settle) state_next = S_CMP;
            end
            S_CMP: begin
                state_next = (idx == 3'd7) ? S_DONE : S_CLEAR;
            end
            S_DONE: begin
                resp_valid = 1'b1;
                if (resp_ready) state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= 16'd0;
            idx       <= 3'd0;
            sel       <= 4'd0;
            resp      <= 8'd0;
            resp_mask <= 8'd0;
        end else begin
            if (state_next != state) begin
                cnt <= 16'd0;
            end else if (state == S_RUN || state == S_SETTLE) begin
                cnt <= cnt + 16'd1;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sel       <= base_chal;
                        idx       <= 3'd0;
                        resp      <= 8'd0;
                        resp_mask <= 8'd0;
                    end
                end
                S_CMP: begin
                    resp[idx]      <= cmp_bit;
                    resp_mask[idx] <= cmp_unstable;
                    if (idx != 3'd7) begin
                        idx <= idx + 3'd1;
                        sel <= sel + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ro_sel = sel;

endmodule

// File: tb/tb_puf_resp_ctrl.sv
// tb/tb_puf_resp_ctrl.sv - directed self-checking bench for puf_resp_ctrl
module tb_puf_resp_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  base_chal;
    logic [15:0] count_a;
    logic [15:0] count_b;
    logic        ro_en;
    logic        ro_clr;
    logic [3:0]  ro_sel;
    logic        busy;
    logic [7:0]  resp;
    logic [7:0]  resp_mask;
    logic        resp_valid;
    logic        resp_ready;

    int compared;
    int mismatched;
    int mode;
    int clr_total;
    int en_total;
    logic [3:0] sel_log [0:255];

    puf_resp_ctrl #(.WINDOW(16), .SETTLE(2), .MARGIN(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_chal  (base_chal),
        .count_a    (count_a),
        .count_b    (count_b),
        .ro_en      (ro_en),
        .ro_clr     (ro_clr),
        .ro_sel     (ro_sel),
        .busy       (busy),
        .resp       (resp),
        .resp_mask  (resp_mask),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Oscillator bank model: counts depend on the selected challenge
    always_comb begin
        count_a = 16'd200;
        count_b = 16'd100;
        if (mode == 1) begin
            count_a = ro_sel[0] ? 16'd100 : 16'd150;
            count_b = ro_sel[0] ? 16'd150 : 16'd100;
        end else if (mode == 2) begin
            case (ro_sel)
                4'd0: begin count_a = 16'd107; count_b = 16'd100; end
                4'd1: begin count_a = 16'd100; count_b = 16'd108; end
                4'd2: begin count_a = 16'd100; count_b = 16'd100; end
                default: begin count_a = 16'd300; count_b = 16'd100; end
            endcase
        end
    end

    always @(negedge clk) begin
        if (ro_clr) begin
            sel_log[clr_total & 255] = ro_sel;
            clr_total = clr_total + 1;
        end
        if (ro_en) en_total = en_total + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_byte(input logic [3:0] base, input logic [7:0] exp_resp,
                            input logic [7:0] exp_mask, input bit do_ack);
        int c0;
        int e0;
        int lat;
        c0 = clr_total;
        e0 = en_total;
        base_chal = base;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, 160);
        check("resp", resp, exp_resp);
        check("resp_mask", resp_mask, exp_mask);
        check("clr_pulses", clr_total - c0, 8);
        check("en_cycles", en_total - e0, 128);
        for (int i = 0; i < 8; i++) begin
            check("ro_sel_seq", sel_log[(c0 + i) & 255], 4'(base + 4'(i)));
        end
        if (do_ack) begin
            resp_ready = 1'b1;
            @(posedge clk); #1;
            resp_ready = 1'b0;
            check("ack_busy", busy, 0);
            check("ack_valid", resp_valid, 0);
        end
    endtask

    int k;
    int c_start;

    initial begin
        compared   = 0;
        mismatched = 0;
        mode       = 0;
        clr_total  = 0;
        en_total   = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        base_chal  = 4'd0;
        resp_ready = 1'b0;

        @(posedge clk); @(posedge clk); #1;
        check("reset_outputs", {ro_en, ro_clr, ro_sel, busy, resp, resp_mask, resp_valid}, 0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_after_reset", {busy, resp_valid, ro_en}, 0);

        mode = 0;
        run_byte(4'd3, 8'hFF, 8'h00, 1'b1);

        mode = 1;
        run_byte(4'd0, 8'h55, 8'h00, 1'b1);

        mode = 2;
        run_byte(4'd0, 8'hF9, 8'h05, 1'b1);

        // Wrap and backpressure
        mode = 1;
        run_byte(4'd12, 8'h55, 8'h00, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (i == 10) begin
                base_chal = 4'd5;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            check("bp_valid", resp_valid, 1);
            check("bp_resp", {resp, resp_mask}, 16'h5500);
        end
        start = 1'b1;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        resp_ready = 1'b0;
        check("bp_busy_low", busy, 0);
        check("bp_valid_low", resp_valid, 0);
        @(posedge clk); #1;
        check("start_in_done_ignored", busy, 0);
        check("resp_kept_idle", {resp, resp_mask}, 16'h5500);

        // Reset mid-RUN of bit 4
        mode = 0;
        base_chal = 4'd0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c_start = clr_total;
        k = 0;
        while ((clr_total - c_start) < 5 && k < 1000) begin
            @(posedge clk); #1;
            k++;
        end
        check("reach_bit4_bound", (k < 1000), 1);
        repeat (5) @(posedge clk);
        #1;
        check("bit4_running", {ro_en, ro_sel}, {1'b1, 4'd4});
        #2;
        rst_n = 1'b0;
        #1;
        check("async_ro_en", ro_en, 0);
        check("reset_mid_outputs", {ro_en, ro_clr, ro_sel, busy, resp, resp_mask, resp_valid}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_after_abort", {busy, resp_valid}, 0);
        run_byte(4'd9, 8'hFF, 8'h00, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
